// File: rtl/id_exe_if.sv
// Bundle of ID-side inputs, pipeline controls and EXE-side registered outputs
// for the ID/EXE pipeline register.
interface id_exe_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             freeze;
  logic             flush;
  logic             hazard;
  logic [3:0]       exe_cmd_in;
  logic             mem_read_in;
  logic             mem_write_in;
  logic             wb_en_in;
  logic             branch_in;
  logic             s_in;
  logic [WIDTH-1:0] pc_in;
  logic [WIDTH-1:0] val_rn_in;
  logic [WIDTH-1:0] val_rm_in;
  logic             imm_in;
  logic [11:0]      shift_operand_in;
  logic [23:0]      signed_imm24_in;
  logic [3:0]       dest_in;
  logic [3:0]       src1_in;
  logic [3:0]       src2_in;
  logic             carry_in;

  logic [3:0]       exe_cmd;
  logic             mem_read;
  logic             mem_write;
  logic             wb_en;
  logic             branch;
  logic             s;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] val_rn;
  logic [WIDTH-1:0] val_rm;
  logic             imm;
  logic [11:0]      shift_operand;
  logic [23:0]      signed_imm24;
  logic [3:0]       dest;
  logic [3:0]       src1;
  logic [3:0]       src2;
  logic             carry;
  logic             valid;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output freeze, flush, hazard, exe_cmd_in, mem_read_in, mem_write_in,
           wb_en_in, branch_in, s_in, pc_in, val_rn_in, val_rm_in, imm_in,
           shift_operand_in, signed_imm24_in, dest_in, src1_in, src2_in, carry_in,
    input  exe_cmd, mem_read, mem_write, wb_en, branch, s, pc, val_rn, val_rm,
           imm, shift_operand, signed_imm24, dest, src1, src2, carry, valid,
           bubble_cnt, flush_cnt
  );

  modport slave (
    input  freeze, flush, hazard, exe_cmd_in, mem_read_in, mem_write_in,
           wb_en_in, branch_in, s_in, pc_in, val_rn_in, val_rm_in, imm_in,
           shift_operand_in, signed_imm24_in, dest_in, src1_in, src2_in, carry_in,
    output exe_cmd, mem_read, mem_write, wb_en, branch, s, pc, val_rn, val_rm,
           imm, shift_operand, signed_imm24, dest, src1, src2, carry, valid,
           bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with freeze (stall), bubble (load-use) and flush
// (taken branch) actions, plus saturating bubble/flush event counters.
module id_exe_stage_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst,
  id_exe_if.slave     bus
);

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       branch;
    logic       s;
  } ctrl_t;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] val_rn;
    logic [WIDTH-1:0] val_rm;
    logic             imm;
    logic [11:0]      shift_operand;
    logic [23:0]      signed_imm24;
    logic [3:0]       dest;
    logic [3:0]       src1;
    logic [3:0]       src2;
    logic             carry;
  } data_t;

  ctrl_t            ctrl_d, ctrl_q;
  data_t            data_d, data_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
  ctrl_t            ctrl_in;
  data_t            data_in;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign ctrl_in = '{exe_cmd: bus.exe_cmd_in, mem_read: bus.mem_read_in,
                     mem_write: bus.mem_write_in, wb_en: bus.wb_en_in,
                     branch: bus.branch_in, s: bus.s_in};
  assign data_in = '{pc: bus.pc_in, val_rn: bus.val_rn_in, val_rm: bus.val_rm_in,
                     imm: bus.imm_in, shift_operand: bus.shift_operand_in,
                     signed_imm24: bus.signed_imm24_in, dest: bus.dest_in,
                     src1: bus.src1_in, src2: bus.src2_in, carry: bus.carry_in};

  always_comb begin
    ctrl_d       = ctrl_q;
    data_d       = data_q;
    valid_d      = valid_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (!bus.freeze) begin
      data_d = data_in;
      // Flush and bubble both yield an all-zero control word; flush wins the count.
      if (bus.flush || bus.hazard) begin
        ctrl_d  = '0;
        valid_d = 1'b0;
      end else begin
        ctrl_d  = ctrl_in;
        valid_d = 1'b1;
      end
      if (bus.flush)       flush_cnt_d  = sat_inc(flush_cnt_q);
      else if (bus.hazard) bubble_cnt_d = sat_inc(bubble_cnt_q);
    end
  end

  // ID -> EXE boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q       <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.exe_cmd       = ctrl_q.exe_cmd;
  assign bus.mem_read      = ctrl_q.mem_read;
  assign bus.mem_write     = ctrl_q.mem_write;
  assign bus.wb_en         = ctrl_q.wb_en;
  assign bus.branch        = ctrl_q.branch;
  assign bus.s             = ctrl_q.s;
  assign bus.pc            = data_q.pc;
  assign bus.val_rn        = data_q.val_rn;
  assign bus.val_rm        = data_q.val_rm;
  assign bus.imm           = data_q.imm;
  assign bus.shift_operand = data_q.shift_operand;
  assign bus.signed_imm24  = data_q.signed_imm24;
  assign bus.dest          = data_q.dest;
  assign bus.src1          = data_q.src1;
  assign bus.src2          = data_q.src2;
  assign bus.carry         = data_q.carry;
  assign bus.valid         = valid_q;
  assign bus.bubble_cnt    = bubble_cnt_q;
  assign bus.flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Randomized bench for id_exe_stage_reg (4-bit counters to reach saturation)
// against an event-level reference model.
module tb_id_exe_stage_reg;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  id_exe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  id_exe_stage_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference state: what the EXE slot should hold after each edge.
  logic [8:0]       m_ctrl;
  logic             m_valid;
  logic [WIDTH-1:0] m_pc, m_rn, m_rm;
  logic [49:0]      m_misc;
  int               m_bc, m_fc;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] in_ctrl();
    return {bus.exe_cmd_in, bus.mem_read_in, bus.mem_write_in, bus.wb_en_in,
            bus.branch_in, bus.s_in};
  endfunction

  function automatic logic [49:0] in_misc();
    return {bus.imm_in, bus.shift_operand_in, bus.signed_imm24_in, bus.dest_in,
            bus.src1_in, bus.src2_in, bus.carry_in};
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_ctrl = '0; m_valid = 1'b0; m_pc = '0; m_rn = '0; m_rm = '0; m_misc = '0;
      m_bc = 0; m_fc = 0;
    end else if (!bus.freeze) begin
      m_pc = bus.pc_in; m_rn = bus.val_rn_in; m_rm = bus.val_rm_in; m_misc = in_misc();
      if (bus.flush) begin
        m_ctrl = '0; m_valid = 1'b0;
        m_fc = (m_fc + 1 > CMAX) ? CMAX : m_fc + 1;
      end else if (bus.hazard) begin
        m_ctrl = '0; m_valid = 1'b0;
        m_bc = (m_bc + 1 > CMAX) ? CMAX : m_bc + 1;
      end else begin
        m_ctrl = in_ctrl(); m_valid = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    check("ctrl", 64'({bus.exe_cmd, bus.mem_read, bus.mem_write, bus.wb_en,
                      bus.branch, bus.s}), 64'(m_ctrl));
    check("valid", 64'(bus.valid), 64'(m_valid));
    check("pc", 64'(bus.pc), 64'(m_pc));
    check("val_rn", 64'(bus.val_rn), 64'(m_rn));
    check("val_rm", 64'(bus.val_rm), 64'(m_rm));
    check("misc", 64'({bus.imm, bus.shift_operand, bus.signed_imm24, bus.dest,
                      bus.src1, bus.src2, bus.carry}), 64'(m_misc));
    check("bubble_cnt", 64'(bus.bubble_cnt), 64'(m_bc));
    check("flush_cnt", 64'(bus.flush_cnt), 64'(m_fc));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic rand_inputs();
    bus.exe_cmd_in       = 4'($urandom);
    bus.mem_read_in      = 1'($urandom);
    bus.mem_write_in     = 1'($urandom);
    bus.wb_en_in         = 1'($urandom);
    bus.branch_in        = 1'($urandom);
    bus.s_in             = 1'($urandom);
    bus.pc_in            = $urandom;
    bus.val_rn_in        = $urandom;
    bus.val_rm_in        = $urandom;
    bus.imm_in           = 1'($urandom);
    bus.shift_operand_in = 12'($urandom);
    bus.signed_imm24_in  = 24'($urandom);
    bus.dest_in          = 4'($urandom);
    bus.src1_in          = 4'($urandom);
    bus.src2_in          = 4'($urandom);
    bus.carry_in         = 1'($urandom);
  endtask

  task automatic set_pipe(input logic fr, input logic fl, input logic hz);
    bus.freeze = fr; bus.flush = fl; bus.hazard = hz;
  endtask

  initial begin
    rst = 1'b1;
    set_pipe(1'b0, 1'b0, 1'b0);
    rand_inputs();
    m_ctrl = '0; m_valid = 1'b0; m_pc = '0; m_rn = '0; m_rm = '0; m_misc = '0;
    m_bc = 0; m_fc = 0;

    // Reset with random inputs and random pipeline controls
    for (int i = 0; i < 2; i++) begin
      set_pipe(1'($urandom), 1'($urandom), 1'($urandom));
      cycle();
      rand_inputs();
    end
    check("rst_valid", 64'(bus.valid), 64'(0));

    // Release reset: first instruction writes back with exe_cmd 2
    rst = 1'b0;
    set_pipe(1'b0, 1'b0, 1'b0);
    bus.wb_en_in = 1'b1; bus.exe_cmd_in = 4'b0010;
    cycle();
    check("first_wb", 64'({bus.wb_en, bus.exe_cmd, bus.valid}), 64'({1'b1, 4'd2, 1'b1}));

    // Normal streaming
    bus.pc_in = 32'h10; bus.val_rn_in = 32'hA5; bus.dest_in = 4'd3;
    cycle();
    check("pass_pc", 64'(bus.pc), 64'h10);
    for (int i = 0; i < 5; i++) begin rand_inputs(); cycle(); end

    // Freeze with flush pending, then release
    bus.exe_cmd_in = 4'b0100;
    cycle();
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      set_pipe(1'b1, 1'b1, 1'($urandom));
      cycle();
      check("frz_cmd", 64'(bus.exe_cmd), 64'(4'b0100));
    end
    set_pipe(1'b0, 1'b1, 1'b0);
    cycle();
    check("frz_rel_fc", 64'(bus.flush_cnt), 64'(1));

    // Bubble after a valid instruction
    set_pipe(1'b0, 1'b0, 1'b0);
    rand_inputs(); bus.wb_en_in = 1'b1;
    cycle();
    set_pipe(1'b0, 1'b0, 1'b1);
    bus.mem_read_in = 1'b1; bus.wb_en_in = 1'b1;
    cycle();
    check("bub_bc", 64'(bus.bubble_cnt), 64'(1));
    set_pipe(1'b0, 1'b0, 1'b0);
    cycle();

    // Flush and hazard together
    set_pipe(1'b0, 1'b1, 1'b1);
    rand_inputs();
    cycle();
    check("fh_bc", 64'(bus.bubble_cnt), 64'(1));

    // Bubble counter saturation, then reset clears it
    set_pipe(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin rand_inputs(); cycle(); end
    check("sat_bc", 64'(bus.bubble_cnt), 64'(CMAX));
    rst = 1'b1;
    set_pipe(1'b1, 1'b1, 1'b1);
    cycle();
    check("rst_bc", 64'(bus.bubble_cnt), 64'(0));
    rst = 1'b0;

    // Random mix of stalls, bubbles, flushes and occasional resets
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      set_pipe(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 3) == 0));
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_exe_stage_reg.md
Name: id_exe_stage_reg

Overview:
Pipeline register between the instruction-decode stage and the execute stage of the 5-stage ARM core. It captures the decoded control word (exe_cmd, memory/writeback/branch flags, status_update) and the operand fields every cycle. It supports three pipeline actions:
- freeze: memory-stall hold.
- bubble: load-use hazard NOP insertion.
- flush: taken-branch squash.

It also keeps saturating bubble and flush counters for performance debug.

Parameters:
WIDTH, 32, datapath width of PC and register values
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
freeze  in  1  hold all state (memory stall)
flush  in  1  squash ID instruction (taken branch in EXE)
hazard  in  1  insert bubble (load-use hazard detected in ID)
exe_cmd_in  in  4  ALU command from decode
mem_read_in, mem_write_in, wb_en_in, branch_in, s_in  in  1 each  decoded control flags (s_in = status_update)
pc_in  in  WIDTH  PC+4 of ID instruction
val_rn_in, val_rm_in  in  WIDTH  register-file read values
imm_in  in  1  immediate-operand flag
shift_operand_in  in  12  shifter operand field
signed_imm24_in  in  24  branch offset
dest_in, src1_in, src2_in  in  4 each  register indices
carry_in  in  1  C flag from status register
exe_cmd, mem_read, mem_write, wb_en, branch, s, pc, val_rn, val_rm, imm, shift_operand, signed_imm24, dest, src1, src2, carry  out  (widths as inputs)  registered copies
valid  out  1  1 = EXE slot holds a real instruction
bubble_cnt  out  CNT_W  bubbles inserted since reset
flush_cnt  out  CNT_W  flushes applied since reset

Behaviour:
- All updates occur on the rising edge of clk. Outputs are registers with no combinational paths.
- Latency: 1 cycle from inputs to outputs.
- Control fields: exe_cmd, mem_read, mem_write, wb_en, branch, s.
- Priority per edge: rst > freeze > flush > hazard > normal load.
- rst: every output is 0, including valid, data fields, and both counters.
- freeze=1: all registers hold, counters included. flush and hazard are ignored that cycle; the upstream stage keeps asserting them until freeze drops.
- flush=1 (freeze=0):
  - Control fields and valid are cleared to 0.
  - Data fields load the input values (don't-care contents).
  - flush_cnt increments.
- hazard=1 (freeze=0, flush=0):
  - Control fields and valid are cleared (bubble); data fields load.
  - bubble_cnt increments.
- flush and hazard together: flush applies; bubble_cnt is not incremented.
- Normal load: every field loads from its input and valid=1.
- Counters saturate at 2^CNT_W-1 and never wrap.
- A cleared control word must equal exactly 0 in all six control fields, so that downstream stages and the hazard unit see no writeback and no memory access.
- Reset asserted mid-stall or mid-flush overrides everything on that same edge.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs → all outputs 0 and valid=0. Release rst with wb_en_in=1, exe_cmd_in=4'b0010 → next edge gives wb_en=1, exe_cmd=2, valid=1.
- Normal pass: drive pc_in=0x10, val_rn_in=0xA5, dest_in=3 → the same values appear at outputs exactly one edge later; a new value each cycle streams with 1-cycle latency.
- Freeze: load exe_cmd=4'b0100, then freeze=1 for 3 cycles while inputs change and flush=1 → outputs stay 4'b0100 and flush_cnt is unchanged. Drop freeze with flush still 1 → control cleared and flush_cnt=1.
- Bubble: load a valid ADD, then hazard=1 for one cycle with mem_read_in=1 → mem_read=0, wb_en=0, valid=0, bubble_cnt=1. The next cycle (hazard=0) loads normally.
- Flush+hazard together: both asserted → controls are 0, flush_cnt increments, bubble_cnt is unchanged.
- Saturation: with CNT_W=4, assert hazard for 20 cycles → bubble_cnt reaches 15 and stays at 15. Then rst=1 → bubble_cnt is 0.
